// File: rtl/perf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : perf_pkg
// Description : Shared address map, CFG field layout and counting mode for
//               the performance counter bank.
// Revision    : 1.0 - initial release
// ============================================================================
package perf_pkg;

  localparam logic [7:0] CFG_BASE  = 8'h00;
  localparam logic [7:0] CNT_BASE  = 8'h40;
  localparam logic [7:0] SNAP_BASE = 8'h80;
  localparam logic [7:0] CTRL_ADDR = 8'hC0;
  localparam logic [7:0] OVF_ADDR  = 8'hC1;

  localparam int CFG_W      = 10;
  localparam int CFG_EN     = 0;
  localparam int CFG_SAT    = 1;
  localparam int CFG_WT_LO  = 2;
  localparam int CFG_WT_HI  = 3;
  localparam int CFG_SEL_LO = 4;
  localparam int CFG_SEL_HI = 8;
  localparam int CFG_IE     = 9;

  localparam int CTRL_RUN  = 0;
  localparam int CTRL_SNAP = 1;
  localparam int CTRL_CLR  = 2;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

endpackage
`default_nettype wire

// File: rtl/perf_channel.sv
`default_nettype none
// ============================================================================
// Module      : perf_channel
// Description : One counter channel: CFG, live count, snapshot, weighted
//               adder with wrap or saturate, and a per-edge overflow strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_channel
  import perf_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 nrst,
  input  logic [31:0]          evt,
  input  logic                 count_en,
  input  logic                 clear,
  input  logic                 snap,
  input  logic                 cfg_we,
  input  logic                 cnt_we,
  input  logic [CNT_WIDTH-1:0] wdata,
  output logic [CFG_W-1:0]     cfg,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic [CNT_WIDTH-1:0] snap_val,
  output logic                 ovf_set
);

  logic [CFG_W-1:0]     r_cfg;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_snap;

  logic [4:0]           w_sel;
  logic [1:0]           w_weight;
  cnt_mode_e            w_mode;
  logic                 w_inc;
  logic [CNT_WIDTH:0]   w_sum;
  logic                 w_carry;
  logic [CNT_WIDTH-1:0] w_next;

  assign w_sel    = r_cfg[CFG_SEL_HI:CFG_SEL_LO];
  assign w_weight = r_cfg[CFG_WT_HI:CFG_WT_LO];
  assign w_mode   = cnt_mode_e'(r_cfg[CFG_SAT]);

  // evt arrives zero-padded to 32 bits, so out-of-range selects read 0
  assign w_inc   = count_en & r_cfg[CFG_EN] & evt[w_sel] & (w_weight != 2'd0);
  assign w_sum   = {1'b0, r_cnt} + (CNT_WIDTH+1)'(w_weight);
  assign w_carry = w_sum[CNT_WIDTH];

  always_comb begin
    w_next = w_sum[CNT_WIDTH-1:0];
    if (w_mode == MODE_SAT && w_carry)
      w_next = '1;
  end

  // An increment discarded by clear or a software write cannot overflow
  assign ovf_set = w_inc & w_carry & ~clear & ~cnt_we;

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      r_cfg  <= '0;
      r_cnt  <= '0;
      r_snap <= '0;
    end else begin
      if (cfg_we)
        r_cfg <= wdata[CFG_W-1:0];
      if (snap)
        r_snap <= r_cnt;
      if (clear)
        r_cnt <= '0;
      else if (cnt_we)
        r_cnt <= wdata;
      else if (w_inc)
        r_cnt <= w_next;
    end
  end

  assign cfg      = r_cfg;
  assign cnt      = r_cnt;
  assign snap_val = r_snap;

endmodule
`default_nettype wire

// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : perf_counter_bank
// Description : Bank of weighted event counters with register access,
//               atomic snapshot, clear-all and sticky overflow interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNT   = 8,
  parameter int CNT_WIDTH = 32,
  parameter int NUM_EVT   = 16
) (
  input  logic                 CLK,
  input  logic                 nrst,
  input  logic [NUM_EVT-1:0]   evt,
  input  logic                 freeze,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_addr,
  input  logic [CNT_WIDTH-1:0] cfg_wdata,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic                 ovf_irq
);

  logic                 r_run;
  logic [NUM_CNT-1:0]   r_ovf;
  logic                 r_irq;
  logic [CNT_WIDTH-1:0] r_rd;

  logic [31:0]          w_evt32;
  logic [5:0]           w_idx;
  logic                 w_ctrl_wr;
  logic                 w_snap;
  logic                 w_clear;
  logic                 w_count_en;
  logic [NUM_CNT-1:0]   w_w1c;
  logic [NUM_CNT-1:0]   w_ovf_set;
  logic [NUM_CNT-1:0]   w_ie;
  logic [CNT_WIDTH-1:0] w_rd;

  logic [CFG_W-1:0]     w_cfg  [NUM_CNT];
  logic [CNT_WIDTH-1:0] w_cnt  [NUM_CNT];
  logic [CNT_WIDTH-1:0] w_snapv[NUM_CNT];

  assign w_evt32    = 32'(evt);
  assign w_idx      = cfg_addr[5:0];
  assign w_ctrl_wr  = cfg_we && (cfg_addr == CTRL_ADDR);
  assign w_snap     = w_ctrl_wr && cfg_wdata[CTRL_SNAP];
  assign w_clear    = w_ctrl_wr && cfg_wdata[CTRL_CLR];
  assign w_count_en = r_run & ~freeze;
  assign w_w1c      = (cfg_we && (cfg_addr == OVF_ADDR)) ? cfg_wdata[NUM_CNT-1:0] : '0;

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_ch
    logic w_cfg_we;
    logic w_cnt_we;

    assign w_cfg_we = cfg_we && (cfg_addr[7:6] == CFG_BASE[7:6]) && (w_idx == 6'(k));
    assign w_cnt_we = cfg_we && (cfg_addr[7:6] == CNT_BASE[7:6]) && (w_idx == 6'(k));

    perf_channel #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_channel (
      .CLK      (CLK),
      .nrst     (nrst),
      .evt      (w_evt32),
      .count_en (w_count_en),
      .clear    (w_clear),
      .snap     (w_snap),
      .cfg_we   (w_cfg_we),
      .cnt_we   (w_cnt_we),
      .wdata    (cfg_wdata),
      .cfg      (w_cfg[k]),
      .cnt      (w_cnt[k]),
      .snap_val (w_snapv[k]),
      .ovf_set  (w_ovf_set[k])
    );

    assign w_ie[k] = w_cfg[k][CFG_IE];
  end

  // Read mux sees pre-write state, so read-during-write returns the old value
  always_comb begin
    w_rd = '0;
    case (cfg_addr[7:6])
      CFG_BASE[7:6]: begin
        for (int k = 0; k < NUM_CNT; k++)
          if (w_idx == 6'(k)) w_rd = CNT_WIDTH'(w_cfg[k]);
      end
      CNT_BASE[7:6]: begin
        for (int k = 0; k < NUM_CNT; k++)
          if (w_idx == 6'(k)) w_rd = w_cnt[k];
      end
      SNAP_BASE[7:6]: begin
        for (int k = 0; k < NUM_CNT; k++)
          if (w_idx == 6'(k)) w_rd = w_snapv[k];
      end
      default: begin
        if (cfg_addr == CTRL_ADDR)
          w_rd = CNT_WIDTH'(r_run);
        else if (cfg_addr == OVF_ADDR)
          w_rd = CNT_WIDTH'(r_ovf);
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      r_run <= 1'b0;
      r_ovf <= '0;
      r_irq <= 1'b0;
      r_rd  <= '0;
    end else begin
      if (w_ctrl_wr)
        r_run <= cfg_wdata[CTRL_RUN];
      if (w_clear)
        r_ovf <= '0;
      else
        r_ovf <= (r_ovf & ~w_w1c) | w_ovf_set;
      r_irq <= |(r_ovf & w_ie);
      r_rd  <= w_rd;
    end
  end

  assign rd_data = r_rd;
  assign ovf_irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_perf_counter_bank
// Description : Scoreboard bench for perf_counter_bank register reads and irq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_counter_bank;

  localparam int NUM_CNT   = 8;
  localparam int CNT_WIDTH = 32;
  localparam int NUM_EVT   = 16;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] exp;
  } rd_item_t;

  logic                 CLK = 1'b0;
  logic                 nrst;
  logic [NUM_EVT-1:0]   evt;
  logic                 freeze;
  logic                 cfg_we;
  logic [7:0]           cfg_addr;
  logic [CNT_WIDTH-1:0] cfg_wdata;
  logic [CNT_WIDTH-1:0] rd_data;
  logic                 ovf_irq;

  logic     issue = 1'b0;
  logic     pend  = 1'b0;
  rd_item_t sb[$];
  int       n_checks = 0;
  int       n_fail   = 0;

  perf_counter_bank #(
    .NUM_CNT   (NUM_CNT),
    .CNT_WIDTH (CNT_WIDTH),
    .NUM_EVT   (NUM_EVT)
  ) dut (
    .CLK       (CLK),
    .nrst      (nrst),
    .evt       (evt),
    .freeze    (freeze),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .rd_data   (rd_data),
    .ovf_irq   (ovf_irq)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge CLK) pend <= issue;

  always @(negedge CLK) begin
    if (pend) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
        rd_item_t it;
        it = sb.pop_front();
        check_eq($sformatf("rd[%02h]", it.addr), rd_data, it.exp);
      end
    end
  end

  task automatic drive(input logic we, input logic [7:0] a, input logic [31:0] d,
                       input logic do_rd, input logic [31:0] exp);
    rd_item_t it;
    cfg_we    = we;
    cfg_addr  = a;
    cfg_wdata = d;
    issue     = do_rd;
    if (do_rd) begin
      it.addr = a;
      it.exp  = exp;
      sb.push_back(it);
    end
    @(negedge CLK);
    cfg_we = 1'b0;
    issue  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    drive(1'b1, a, d, 1'b0, 32'd0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp);
    drive(1'b0, a, 32'd0, 1'b1, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    repeat (20000) @(posedge CLK);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst = 1'b0; evt = '0; freeze = 1'b0;
    cfg_we = 1'b0; cfg_addr = 8'h00; cfg_wdata = '0;
    repeat (3) @(negedge CLK);
    check_eq("reset_rd_data", rd_data, 32'd0);
    check_eq("reset_irq", {31'd0, ovf_irq}, 32'd0);
    nrst = 1'b1;

    // Whole map reads zero after reset
    for (int a = 0; a <= 8'hC1; a++) rd(8'(a), 32'd0);
    check_eq("irq_idle", {31'd0, ovf_irq}, 32'd0);

    // Basic counting, weights 1 and 2 on evt[3]
    wr(8'h00, 32'h035);
    wr(8'h01, 32'h039);
    wr(8'hC0, 32'h1);
    evt = 16'h0008; idle(10); evt = '0;
    rd(8'h40, 32'd10);
    rd(8'h41, 32'd20);
    rd(8'h00, 32'h035);
    rd(8'hC0, 32'h1);

    // Wrap with carry-out on channel 2 (evt[5], weight 3, ie)
    wr(8'h02, 32'h25D);
    wr(8'h42, 32'hFFFF_FFFE);
    evt = 16'h0020; idle(1); evt = '0;
    idle(1);
    check_eq("wrap_irq", {31'd0, ovf_irq}, 32'd1);
    rd(8'h42, 32'd1);
    rd(8'hC1, 32'h4);
    wr(8'hC1, 32'h4);
    rd(8'hC1, 32'h0);
    check_eq("w1c_irq", {31'd0, ovf_irq}, 32'd0);

    // Saturation holds at all-ones
    wr(8'h02, 32'h25F);
    wr(8'h42, 32'hFFFF_FFFE);
    evt = 16'h0020; idle(3); evt = '0;
    rd(8'h42, 32'hFFFF_FFFF);
    rd(8'hC1, 32'h4);
    wr(8'hC1, 32'h4);
    idle(1);
    rd(8'hC1, 32'h0);

    // Snapshot + clear_all with an event on the same edge
    wr(8'h03, 32'h065);
    evt = 16'h0040; idle(7);
    wr(8'hC0, 32'h7);
    idle(1); evt = '0;
    rd(8'h83, 32'd7);
    rd(8'h43, 32'd1);
    rd(8'h80, 32'd10);
    rd(8'h81, 32'd20);
    rd(8'h82, 32'hFFFF_FFFF);
    rd(8'h40, 32'd0);
    rd(8'hC0, 32'h1);
    rd(8'hC1, 32'h0);

    // Freeze, then software write beating a coincident increment
    freeze = 1'b1; evt = 16'h0008; idle(5);
    rd(8'h40, 32'd0);
    freeze = 1'b0;
    wr(8'h40, 32'd100);
    evt = '0;
    rd(8'h40, 32'd100);
    rd(8'h41, 32'd2);
    drive(1'b1, 8'h40, 32'd55, 1'b1, 32'd100);
    rd(8'h40, 32'd55);

    // Weight 0 and out-of-range evt_sel never count
    wr(8'h04, 32'h031);
    wr(8'h05, 32'h145);
    evt = 16'hFFFF; idle(3); evt = '0;
    rd(8'h44, 32'd0);
    rd(8'h45, 32'd0);
    rd(8'h40, 32'd58);
    rd(8'h41, 32'd8);
    rd(8'h42, 32'd9);
    rd(8'h43, 32'd4);

    // Unmapped addresses
    wr(8'h48, 32'd5);
    rd(8'h48, 32'd0);
    rd(8'h88, 32'd0);
    rd(8'hC2, 32'd0);
    rd(8'h08, 32'd0);

    // Clearing run still lets that edge's event count
    evt = 16'h0008;
    wr(8'hC0, 32'h0);
    idle(2); evt = '0;
    rd(8'h40, 32'd59);
    rd(8'hC0, 32'h0);

    // Reset mid-operation with irq active
    wr(8'hC0, 32'h1);
    wr(8'h42, 32'hFFFF_FFFE);
    evt = 16'h0020; idle(1); evt = '0;
    idle(1);
    check_eq("pre_rst_irq", {31'd0, ovf_irq}, 32'd1);
    nrst = 1'b0; evt = 16'h0020;
    idle(1);
    check_eq("mid_rst_rd_data", rd_data, 32'd0);
    check_eq("mid_rst_irq", {31'd0, ovf_irq}, 32'd0);
    nrst = 1'b1; evt = '0;
    rd(8'h42, 32'd0);
    rd(8'h02, 32'd0);
    rd(8'hC0, 32'd0);
    rd(8'hC1, 32'd0);
    idle(2);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
